alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
Multi-cycle execution controller that sequences the shared 10-bit ALU. It accepts one instruction at a time over a valid/ready handshake, reads operands from the register file (synchronous read port, 1-cycle latency), presents them to the ALU and registers the result. It then writes back to the register file and updates the architectural S/G flags. It sits between instruction decode and the ALU/register file and serialises all ALU use.

Parameters:
DATA_W, 10, operand/result width (signed two's complement)
RA_W, 3, register-file address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  controller idle, can accept
instr_opcode  in  5  ALU opcode
instr_rd  in  RA_W  destination register
instr_rs1  in  RA_W  source register 1
instr_rs2  in  RA_W  source register 2 (register forms)
instr_imm  in  DATA_W  immediate (immediate forms)
rf_raddr  out  RA_W  register-file read address
rf_rdata  in  DATA_W  read data, valid the cycle after rf_raddr
rf_we  out  1  register-file write enable
rf_waddr  out  RA_W  write address
rf_wdata  out  DATA_W  write data
alu_opcode  out  5  to ALU
alu_op1  out  DATA_W  to ALU
alu_op2  out  DATA_W  to ALU
alu_res  in  DATA_W  from ALU
alu_s  in  1  from ALU, result negative
alu_g  in  1  from ALU, op1 > op2 (signed)
flag_s  out  1  architectural sign flag
flag_g  out  1  architectural greater flag
done  out  1  one-cycle pulse, write-back cycle
illegal  out  1  one-cycle pulse, unsupported opcode rejected

Behaviour:
- Legal opcodes: 00101/00110 DEC; 00111/01000 XOR; 01001/01010 NAND; 01011/01100 ROR; 10010 INC. Odd opcodes 00101–01011 are register forms (op2 = R[rs2]). Even opcodes 00110–01100 are immediate forms (op2 = imm). DEC/INC are unary (op2 = 0). Any other opcode is illegal.
- States: IDLE, RD1, RD2, EXEC, ALU, WB, ERR.
- IDLE: instr_ready=1. On instr_valid, latch opcode, rd, rs1, rs2 and imm. Go to ERR if the opcode is illegal, else RD1.
- RD1: rf_raddr=rs1.
- RD2: op1_q<=rf_rdata; rf_raddr=rs2.
- EXEC: op2_q<=register form ? rf_rdata : unary ? 0 : imm.
- ALU: ALU sees op1_q/op2_q. res_q<=alu_res, s_q<=alu_s, g_q<=alu_g.
- WB: rf_we=1, rf_waddr=rd_q, rf_wdata=res_q, done=1. flag_s<=s_q and flag_g<=g_q at the end of the cycle. Go to IDLE.
- ERR: illegal=1 for one cycle. No write, flags unchanged. Go to IDLE.
- Latency: handshake in cycle 0, done in cycle 5, instr_ready high again in cycle 6. The earliest next accept is cycle 6 (throughput of 1 instruction per 6 cycles).
- instr_ready=0 in every non-IDLE state; instr_valid is ignored there.
- alu_opcode=opcode_q, alu_op1=op1_q and alu_op2=op2_q are driven in all states. The ALU output is sampled only in the ALU state, because the ALU output is high-Z for unsupported opcodes and is never consumed.
- Rotate amount reduction (op2 mod 10) is done by the ALU; the controller passes op2 unmodified.
- rd may equal rs1 or rs2: reads complete before WB, so there is no hazard.
- Reset (any time, including mid-instruction): state=IDLE. All registers and outputs go to 0, except instr_ready=1 after reset deasserts. An in-flight instruction is discarded with no write-back and no done.
- rf_we, done and illegal are never asserted together.

Decomposition:
- Package alu_ctrl_pkg holds:
  - opcode localparams (OP_DEC_R, OP_DEC_I, OP_XOR_R, OP_XOR_I, OP_NAND_R, OP_NAND_I, OP_ROR_R, OP_ROR_I, OP_INC);
  - state enum ctrl_state_t;
  - functions is_legal(), is_imm() and is_unary().
- No sub-module is required. Decode is the package functions, and FSM plus datapath registers stay in one module.

Test Plan:
1. R1=5, R2=3; XOR register form (00111, rd=R3, rs1=R1, rs2=R2) -> rf_we in cycle 5 with waddr=3, wdata=6; done pulses once; flag_s=0, flag_g=1.
2. R0=0; DEC immediate (00110, rd=R4, rs1=R0) -> wdata=10'h3FF (-1); flag_s=1, flag_g=0.
3. R1=10'h001, R2=12; ROR register form (01011, rd=R5) -> wdata=10'h100 (rotate right by 12 mod 10 = 2).
4. R6=10'h3FF, imm=10'h00F; NAND immediate (01010) -> wdata=10'h3F0.
5. Opcode 5'b00000 -> illegal pulses in cycle 1; no rf_we; flags hold previous values; instr_ready=1 in cycle 2.
6. Reset and throughput:
   - Assert rst during the ALU state -> no rf_we, no done, instr_ready=1 after release.
   - Separately, hold instr_valid with two instructions -> second accepted exactly 6 cycles after the first.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Opcode map, controller state encoding and instruction-decode helpers
// shared by the ALU execution controller.
package alu_ctrl_pkg;

  localparam logic [4:0] OP_DEC_R  = 5'b00101;
  localparam logic [4:0] OP_DEC_I  = 5'b00110;
  localparam logic [4:0] OP_XOR_R  = 5'b00111;
  localparam logic [4:0] OP_XOR_I  = 5'b01000;
  localparam logic [4:0] OP_NAND_R = 5'b01001;
  localparam logic [4:0] OP_NAND_I = 5'b01010;
  localparam logic [4:0] OP_ROR_R  = 5'b01011;
  localparam logic [4:0] OP_ROR_I  = 5'b01100;
  localparam logic [4:0] OP_INC    = 5'b10010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_EXEC,
    ST_ALU,
    ST_WB,
    ST_ERR
  } ctrl_state_t;

  function automatic logic is_legal(input logic [4:0] op);
    return ((op >= OP_DEC_R) && (op <= OP_ROR_I)) || (op == OP_INC);
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return (op == OP_DEC_I) || (op == OP_XOR_I) || (op == OP_NAND_I) || (op == OP_ROR_I);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_DEC_R) || (op == OP_DEC_I) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/alu_exec_ctrl.sv
// Serialises shared-ALU use: accept, read rs1/rs2, execute, write back; done 5 cycles after accept.
// One instruction in flight; instr_ready is low from accept until the controller is back in IDLE.
module alu_exec_ctrl #(
  parameter int DATA_W = 10,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        instr_opcode,
  input  logic [RA_W-1:0]   instr_rd,
  input  logic [RA_W-1:0]   instr_rs1,
  input  logic [RA_W-1:0]   instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [RA_W-1:0]   rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_s,
  input  logic              alu_g,
  output logic              flag_s,
  output logic              flag_g,
  output logic              done,
  output logic              illegal
);
  import alu_ctrl_pkg::*;

  ctrl_state_t       state_q, state_d;
  logic [4:0]        opcode_q, opcode_d;
  logic [RA_W-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_W-1:0] imm_q, imm_d, op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic              s_q, s_d, g_q, g_d, flag_s_q, flag_s_d, flag_g_q, flag_g_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      res_q    <= '0;
      s_q      <= 1'b0;
      g_q      <= 1'b0;
      flag_s_q <= 1'b0;
      flag_g_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      res_q    <= res_d;
      s_q      <= s_d;
      g_q      <= g_d;
      flag_s_q <= flag_s_d;
      flag_g_q <= flag_g_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    res_d       = res_q;
    s_d         = s_q;
    g_d         = g_q;
    flag_s_d    = flag_s_q;
    flag_g_d    = flag_g_q;
    instr_ready = 1'b0;
    rf_raddr    = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Held low while reset is asserted so nothing is offered as accepted then.
        instr_ready = !rst;
        if (instr_valid) begin
          opcode_d = instr_opcode;
          rd_d     = instr_rd;
          rs1_d    = instr_rs1;
          rs2_d    = instr_rs2;
          imm_d    = instr_imm;
          state_d  = is_legal(instr_opcode) ? ST_RD1 : ST_ERR;
        end
      end
      ST_RD1: begin
        rf_raddr = rs1_q;
        state_d  = ST_RD2;
      end
      ST_RD2: begin
        op1_d    = rf_rdata;
        rf_raddr = rs2_q;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        // The rs2 read is issued for every form and simply discarded when unused.
        op2_d   = is_unary(opcode_q) ? '0 : (is_imm(opcode_q) ? imm_q : rf_rdata);
        state_d = ST_ALU;
      end
      ST_ALU: begin
        res_d   = alu_res;
        s_d     = alu_s;
        g_d     = alu_g;
        state_d = ST_WB;
      end
      ST_WB: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = res_q;
        done     = 1'b1;
        flag_s_d = s_q;
        flag_g_d = g_q;
        state_d  = ST_IDLE;
      end
      ST_ERR: begin
        illegal = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign alu_opcode = opcode_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign flag_s     = flag_s_q;
  assign flag_g     = flag_g_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: register file and ALU models around the DUT, directed and
// randomized instructions checked against an architectural model.
module tb_alu_exec_ctrl;
  import alu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, instr_ready;
  logic [4:0] instr_opcode;
  logic [2:0] instr_rd, instr_rs1, instr_rs2;
  logic [9:0] instr_imm;
  logic [2:0] rf_raddr, rf_waddr;
  logic [9:0] rf_rdata, rf_wdata;
  logic       rf_we;
  logic [4:0] alu_opcode;
  logic [9:0] alu_op1, alu_op2, alu_res;
  logic       alu_s, alu_g, flag_s, flag_g, done, illegal;

  logic       pre_we;
  logic [2:0] pre_addr;
  logic [9:0] pre_dat;
  logic [9:0] rf [8];
  logic [9:0] arch [8];
  logic       exp_fs, exp_fg;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [4:0] legal_ops [9] = '{OP_DEC_R, OP_DEC_I, OP_XOR_R, OP_XOR_I, OP_NAND_R,
                                OP_NAND_I, OP_ROR_R, OP_ROR_I, OP_INC};

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(10), .RA_W(3)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_res(alu_res), .alu_s(alu_s), .alu_g(alu_g), .flag_s(flag_s), .flag_g(flag_g),
    .done(done), .illegal(illegal)
  );

  // Register file: synchronous read, one-cycle latency; bench preload port has priority.
  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_dat;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
    rf_rdata <= rf[rf_raddr];
  end

  // ALU model.
  always_comb begin
    logic [19:0] w;
    w = {alu_op1, alu_op1} >> (int'(alu_op2) % 10);
    case (alu_opcode)
      OP_DEC_R, OP_DEC_I:   alu_res = alu_op1 - 10'd1;
      OP_INC:               alu_res = alu_op1 + 10'd1;
      OP_XOR_R, OP_XOR_I:   alu_res = alu_op1 ^ alu_op2;
      OP_NAND_R, OP_NAND_I: alu_res = ~(alu_op1 & alu_op2);
      OP_ROR_R, OP_ROR_I:   alu_res = w[9:0];
      default:              alu_res = '0;
    endcase
    alu_s = alu_res[9];
    alu_g = $signed(alu_op1) > $signed(alu_op2);
  end

  // Architectural reference: the effect of one legal instruction on R[rd] and the flags.
  function automatic void ref_exec(input logic [4:0] op, input logic [9:0] a, rv, imm,
                                   output logic [9:0] r, output logic s, output logic g);
    logic [9:0] b;
    int         n;
    if (op == OP_DEC_R || op == OP_DEC_I || op == OP_INC) b = 10'd0;
    else if (op[0] == 1'b0) b = imm;
    else b = rv;
    n = int'(b) % 10;
    r = 10'd0;
    case (op)
      OP_DEC_R, OP_DEC_I:   r = 10'(int'(a) - 1);
      OP_INC:               r = 10'(int'(a) + 1);
      OP_XOR_R, OP_XOR_I:   r = a ^ b;
      OP_NAND_R, OP_NAND_I: r = ~(a & b);
      default:              for (int i = 0; i < 10; i++) r[i] = a[(i + n) % 10];
    endcase
    s = r[9];
    g = $signed(a) > $signed(b);
  endfunction

  function automatic bit ref_legal(input logic [4:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic poke(input logic [2:0] a, input logic [9:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_dat = v;
    @(negedge clk);
    pre_we = 1'b0;
    arch[a] = v;
  endtask

  // Offers one instruction and records what the DUT does until it is ready again.
  task automatic issue(input logic [4:0] op, input logic [2:0] rd, rs1, rs2, input logic [9:0] imm,
                       output logic rdy0, output int we_cnt, output int we_cyc,
                       output logic [2:0] waddr, output logic [9:0] wdata,
                       output int done_cnt, output int done_cyc, output int ill_cnt,
                       output int ill_cyc, output int rdy_cyc);
    we_cnt = 0; we_cyc = -1; done_cnt = 0; done_cyc = -1; ill_cnt = 0; ill_cyc = -1;
    rdy_cyc = -1; waddr = '0; wdata = '0;
    @(negedge clk);
    rdy0 = instr_ready;
    instr_valid = 1'b1; instr_opcode = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
      if (rf_we) begin we_cnt++; we_cyc = k; waddr = rf_waddr; wdata = rf_wdata; end
      if (done) begin done_cnt++; done_cyc = k; end
      if (illegal) begin ill_cnt++; ill_cyc = k; end
      if (instr_ready) begin rdy_cyc = k; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr_opcode = '0; instr_rd = '0;
    instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0; pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    exp_fs = 1'b0; exp_fg = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({rf_we, done, illegal, flag_s, flag_g, alu_op1, alu_op2, alu_opcode, rf_waddr, rf_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b done=%b ill=%b fs=%b fg=%b op1=%h op2=%h opc=%h, all required 0",
               rf_we, done, illegal, flag_s, flag_g, alu_op1, alu_op2, alu_opcode);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: instr_ready=%b required 1", instr_ready);
    end
  endtask

  typedef struct {
    logic [4:0] op; logic [2:0] rd, rs1, rs2; logic [9:0] imm;
    logic [2:0] pa; logic [9:0] va; logic [2:0] pb; logic [9:0] vb;
    logic [9:0] wd; logic fs, fg; bit legal;
  } dir_t;

  task automatic test_directed();
    dir_t t [5];
    logic rdy0; logic [2:0] wa; logic [9:0] wd;
    int wc, wcy, dc, dcy, ic, icy, rcy;
    t[0] = '{OP_XOR_R,  3, 1, 2, 10'h000, 1, 10'd5,   2, 10'd3,   10'h006, 0, 1, 1};
    t[1] = '{OP_DEC_I,  4, 0, 5, 10'h155, 0, 10'd0,   0, 10'd0,   10'h3FF, 1, 0, 1};
    t[2] = '{OP_ROR_R,  5, 1, 2, 10'h000, 1, 10'h001, 2, 10'd12,  10'h100, 0, 0, 1};
    t[3] = '{OP_NAND_I, 7, 6, 0, 10'h00F, 6, 10'h3FF, 0, 10'd0,   10'h3F0, 1, 0, 1};
    t[4] = '{5'b00000,  1, 1, 2, 10'h0AA, 1, 10'd5,   2, 10'd3,   10'h000, 1, 0, 0};
    foreach (t[i]) begin
      poke(t[i].pa, t[i].va);
      poke(t[i].pb, t[i].vb);
      issue(t[i].op, t[i].rd, t[i].rs1, t[i].rs2, t[i].imm, rdy0, wc, wcy, wa, wd, dc, dcy, ic, icy, rcy);
      n_tests++;
      if (t[i].legal ? (wc !== 1 || wcy !== 5 || dc !== 1 || dcy !== 5 || ic !== 0 || rcy !== 6)
                     : (wc !== 0 || dc !== 0 || ic !== 1 || icy !== 1 || rcy !== 2)) begin
        n_fail++;
        $display("FAIL dir%0d_timing: we %0d@%0d done %0d@%0d illegal %0d@%0d ready@%0d, legal=%0d",
                 i, wc, wcy, dc, dcy, ic, icy, rcy, t[i].legal);
      end
      if (t[i].legal) begin
        n_tests++;
        if (wa !== t[i].rd || wd !== t[i].wd) begin
          n_fail++;
          $display("FAIL dir%0d_write: waddr=%0d wdata=%h required waddr=%0d wdata=%h", i, wa, wd, t[i].rd, t[i].wd);
        end
        arch[t[i].rd] = t[i].wd;
      end
      exp_fs = t[i].fs; exp_fg = t[i].fg;
      n_tests++;
      if (flag_s !== exp_fs || flag_g !== exp_fg) begin
        n_fail++;
        $display("FAIL dir%0d_flags: s=%b g=%b required s=%b g=%b", i, flag_s, flag_g, exp_fs, exp_fg);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    poke(1, 10'd7); poke(2, 10'd1); poke(3, 10'h02A);
    @(negedge clk);
    instr_valid = 1'b1; instr_opcode = OP_XOR_R; instr_rd = 3; instr_rs1 = 1; instr_rs2 = 2;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_fs = 1'b0; exp_fg = 1'b0;
    if (rf_we || done) bad++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_tests++;
        if (instr_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL rst_mid_ready: instr_ready=%b required 1", instr_ready);
        end
      end
      if (rf_we || done) bad++;
    end
    n_tests++;
    if (bad !== 0 || rf[3] !== 10'h02A) begin
      n_fail++;
      $display("FAIL rst_mid_discard: we/done cycles=%0d R3=%h required 0 and 02a", bad, rf[3]);
    end
    n_tests++;
    if (flag_s !== 1'b0 || flag_g !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_flags: s=%b g=%b required 0 0", flag_s, flag_g);
    end
  endtask

  task automatic test_back_to_back();
    int acc = -1; int a_cyc = -1; int b_cyc = -1;
    logic [9:0] a_wd = '0, b_wd = '0, ea, eb; logic s, g;
    poke(1, 10'h0FE);
    ref_exec(OP_INC, arch[1], 10'd0, 10'd0, ea, s, g);
    @(negedge clk);
    instr_valid = 1'b1; instr_opcode = OP_INC; instr_rd = 5; instr_rs1 = 1; instr_rs2 = 0; instr_imm = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin instr_opcode = OP_XOR_I; instr_rd = 6; instr_rs1 = 5; instr_imm = 10'h0F0; end
      if (rf_we) begin a_cyc = k; a_wd = rf_wdata; end
      if (instr_ready) begin acc = k; break; end
    end
    arch[5] = ea;
    ref_exec(OP_XOR_I, arch[5], 10'd0, 10'h0F0, eb, s, g);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
      if (rf_we) begin b_cyc = k; b_wd = rf_wdata; end
      if (instr_ready) break;
    end
    arch[6] = eb; exp_fs = s; exp_fg = g;
    n_tests++;
    if (acc !== 6) begin
      n_fail++;
      $display("FAIL b2b_accept: second accept at cycle %0d required 6", acc);
    end
    n_tests++;
    if (a_cyc !== 5 || a_wd !== ea || b_cyc !== 5 || b_wd !== eb) begin
      n_fail++;
      $display("FAIL b2b_results: A %h@%0d B %h@%0d required %h@5 %h@5", a_wd, a_cyc, b_wd, b_cyc, ea, eb);
    end
  endtask

  task automatic test_random();
    logic rdy0; logic [2:0] wa, rd, rs1, rs2; logic [9:0] wd, imm, er; logic [4:0] op; logic s, g;
    int wc, wcy, dc, dcy, ic, icy, rcy; bit lg;
    for (int r = 0; r < 8; r++) poke(3'(r), 10'($urandom));
    for (int it = 0; it < 40; it++) begin
      op  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 8)];
      rd  = 3'($urandom); rs1 = 3'($urandom); rs2 = 3'($urandom); imm = 10'($urandom);
      lg  = ref_legal(op);
      ref_exec(op, arch[rs1], arch[rs2], imm, er, s, g);
      issue(op, rd, rs1, rs2, imm, rdy0, wc, wcy, wa, wd, dc, dcy, ic, icy, rcy);
      n_tests++;
      if (rdy0 !== 1'b1 || (lg ? (wc !== 1 || wcy !== 5 || dc !== 1 || dcy !== 5 || ic !== 0 || rcy !== 6)
                               : (wc !== 0 || dc !== 0 || ic !== 1 || icy !== 1 || rcy !== 2))) begin
        n_fail++;
        $display("FAIL rnd%0d_timing: op=%b rdy0=%b we %0d@%0d done %0d@%0d illegal %0d@%0d ready@%0d legal=%0d",
                 it, op, rdy0, wc, wcy, dc, dcy, ic, icy, rcy, lg);
      end
      if (lg) begin
        n_tests++;
        if (wa !== rd || wd !== er) begin
          n_fail++;
          $display("FAIL rnd%0d_write: op=%b waddr=%0d wdata=%h required waddr=%0d wdata=%h", it, op, wa, wd, rd, er);
        end
        arch[rd] = er; exp_fs = s; exp_fg = g;
      end
      n_tests++;
      if (flag_s !== exp_fs || flag_g !== exp_fg) begin
        n_fail++;
        $display("FAIL rnd%0d_flags: op=%b s=%b g=%b required s=%b g=%b", it, op, flag_s, flag_g, exp_fs, exp_fg);
      end
    end
    for (int r = 0; r < 8; r++) begin
      n_tests++;
      if (rf[r] !== arch[r]) begin
        n_fail++;
        $display("FAIL regfile_R%0d: value=%h required %h", r, rf[r], arch[r]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
